// File: rtl/alu32_if.sv
// Execute-stage ALU bus: operands and command in, registered result and flags out.
interface alu32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [2:0]       command;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             overflow;

  modport master (
    output operandA, operandB, command,
    input  result, carryout, zero, overflow
  );

  modport slave (
    input  operandA, operandB, command,
    output result, carryout, zero, overflow
  );
endinterface

// File: rtl/alu32.sv
// Registered 32-bit ALU: eight ops, result plus carryout/zero/overflow, one-cycle latency.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  alu32_if.slave bus
);
  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             less;

  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             ovf_next;
  logic             zero_next;

  assign a = bus.operandA;
  assign b = bus.operandB;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
  // Correcting the sign bit with the overflow keeps SLT right when A-B wraps.
  assign less    = diff_ext[WIDTH-1] ^ sub_ovf;

  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;
    case (bus.command)
      CMD_ADD: begin
        result_next = sum_ext[WIDTH-1:0];
        carry_next  = sum_ext[WIDTH];
        ovf_next    = add_ovf;
      end
      CMD_SUB: begin
        result_next = diff_ext[WIDTH-1:0];
        carry_next  = diff_ext[WIDTH];
        ovf_next    = sub_ovf;
      end
      CMD_XOR:  result_next = a ^ b;
      CMD_SLT:  result_next = {{(WIDTH-1){1'b0}}, less};
      CMD_AND:  result_next = a & b;
      CMD_NAND: result_next = ~(a & b);
      CMD_NOR:  result_next = ~(a | b);
      CMD_OR:   result_next = a | b;
      default:  result_next = '0;
    endcase
    zero_next = ~(|result_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result   <= '0;
      bus.carryout <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b1;
    end else begin
      bus.result   <= result_next;
      bus.carryout <= carry_next;
      bus.overflow <= ovf_next;
      bus.zero     <= zero_next;
    end
  end
endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: driver queues hand-computed expectations, monitor checks each edge.
module tb_alu32;
  typedef struct {
    string       name;
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t sb_q[$];
  vec_t vecs[$];

  alu32_if #(.WIDTH(32)) bus ();

  alu32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [2:0] cmd, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic c, logic v, logic z);
    vec_t t;
    t.name = n; t.cmd = cmd; t.a = a; t.b = b;
    t.res = res; t.c = c; t.v = v; t.z = z;
    return t;
  endfunction

  task automatic drive(input vec_t t, input bit push);
    @(negedge clk);
    bus.operandA = t.a;
    bus.operandB = t.b;
    bus.command  = t.cmd;
    if (push) sb_q.push_back(t);
  endtask

  task automatic check_reset_state(input string n);
    checks++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.carryout !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: got result=%h c=%b v=%b z=%b, want result=00000000 c=0 v=0 z=1",
               n, bus.result, bus.carryout, bus.overflow, bus.zero);
    end else begin
      $display("txn %s: result=%h c=%b v=%b z=%b ok", n, bus.result, bus.carryout, bus.overflow, bus.zero);
    end
  endtask

  // Monitor: every captured edge out of reset retires exactly one queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && sb_q.size() > 0) begin
        vec_t e;
        e = sb_q.pop_front();
        checks++;
        if (bus.result !== e.res || bus.carryout !== e.c || bus.overflow !== e.v || bus.zero !== e.z) begin
          errors++;
          $display("FAIL %s: got result=%h c=%b v=%b z=%b, want result=%h c=%b v=%b z=%b",
                   e.name, bus.result, bus.carryout, bus.overflow, bus.zero, e.res, e.c, e.v, e.z);
        end else begin
          $display("txn %s: a=%h b=%h cmd=%0d result=%h c=%b v=%b z=%b ok",
                   e.name, e.a, e.b, e.cmd, bus.result, bus.carryout, bus.overflow, bus.zero);
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.operandA = 32'h0;
    bus.operandB = 32'h0;
    bus.command  = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_initial");

    @(negedge clk);
    rst_n = 1'b1;
    // Produce a nonzero result so the mid-stream reset has something to clear.
    drive(mk("pre_reset_add", 3'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0), 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_async");
    bus.operandA = 32'h1234_5678;
    bus.operandB = 32'h0000_0001;
    bus.command  = 3'd0;
    @(posedge clk);
    #1;
    check_reset_state("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk("or_after_reset", 3'd7, 32'h0,        32'h0,        32'h0000_0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("add_0_m1",       3'd0, 32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("add_ovf",        3'd0, 32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("add_m1_1",       3'd0, 32'hFFFF_FFFF, 32'h1,       32'h0000_0000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk("sub_0_1",        3'd1, 32'h0,        32'h1,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("sub_5_5",        3'd1, 32'h5,        32'h5,        32'h0000_0000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk("sub_ovf",        3'd1, 32'h8000_0000, 32'h1,       32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk("slt_0_1",        3'd3, 32'h0,        32'h1,        32'h0000_0001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("slt_1_0",        3'd3, 32'h1,        32'h0,        32'h0000_0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("slt_min_1",      3'd3, 32'h8000_0000, 32'h1,       32'h0000_0001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("slt_1_min",      3'd3, 32'h1,        32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("xor_0_0",        3'd2, 32'h0,        32'h0,        32'h0000_0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("and_1_1",        3'd4, 32'h1,        32'h1,        32'h0000_0001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("nand_1_1",       3'd5, 32'h1,        32'h1,        32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("nor_0_0",        3'd6, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("or_0_0",         3'd7, 32'h0,        32'h0,        32'h0000_0000, 1'b0, 1'b0, 1'b1));
    // Back-to-back sweep of all opcodes with A=12, B=10.
    vecs.push_back(mk("pipe_add",       3'd0, 32'd12, 32'd10, 32'h0000_0016, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("pipe_sub",       3'd1, 32'd12, 32'd10, 32'h0000_0002, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("pipe_xor",       3'd2, 32'd12, 32'd10, 32'h0000_0006, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("pipe_slt",       3'd3, 32'd12, 32'd10, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("pipe_and",       3'd4, 32'd12, 32'd10, 32'h0000_0008, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("pipe_nand",      3'd5, 32'd12, 32'd10, 32'hFFFF_FFF7, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("pipe_nor",       3'd6, 32'd12, 32'd10, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("pipe_or",        3'd7, 32'd12, 32'd10, 32'h0000_000E, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) drive(vecs[i], 1'b1);

    begin
      int wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 20) begin
        @(posedge clk);
        wait_cycles++;
      end
      #2;
      if (sb_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d pending transactions, want 0", sb_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
